// File: rtl/cp0_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cp0_pkg
// Description : Shared constants for the CP0 block. It defines the CP0
//               register numbers, the exception codes, the exception handler
//               address and the mask of implemented SR bits.
// Revision    : 1.0 - initial release
// ============================================================================
package cp0_pkg;

    // CP0 register numbers
    localparam logic [4:0]  c_reg_sr       = 5'd12;
    localparam logic [4:0]  c_reg_cause    = 5'd13;
    localparam logic [4:0]  c_reg_epc      = 5'd14;
    localparam logic [4:0]  c_reg_prid     = 5'd15;

    // Exception codes recorded in Cause.ExcCode
    localparam logic [4:0]  c_exc_int      = 5'd0;
    localparam logic [4:0]  c_exc_adel     = 5'd4;
    localparam logic [4:0]  c_exc_ades     = 5'd5;
    localparam logic [4:0]  c_exc_ri       = 5'd10;
    localparam logic [4:0]  c_exc_ov       = 5'd12;

    // Fetch redirect target when req is raised
    localparam logic [31:0] c_handler_addr = 32'h0000_4180;

    // SR bits that exist: IM[15:10], EXL[1], IE[0]
    localparam logic [31:0] c_sr_mask      = 32'h0000_FC03;

endpackage
`default_nettype wire

// File: rtl/cp0_exc_arb.sv
`default_nettype none
// ============================================================================
// Module      : cp0_exc_arb
// Description : Combinational exception/interrupt arbitration for CP0.
//               An interrupt needs an unmasked line, IE set and EXL clear.
//               A synchronous exception needs a non-zero code and EXL clear.
//               When both are present, the interrupt wins and records code 0.
// Ports       : i_hw_int     - interrupt lines
//               i_im         - SR.IM interrupt mask
//               i_ie, i_exl  - SR.IE / SR.EXL
//               i_exc_code   - pending exception code (0 = none)
//               o_int_req    - interrupt request
//               o_exc_req    - exception request
//               o_code       - ExcCode of the winning request
// Revision    : 1.0 - initial release
// ============================================================================
module cp0_exc_arb
    import cp0_pkg::*;
(
    input  logic [5:0] i_hw_int,
    input  logic [5:0] i_im,
    input  logic       i_ie,
    input  logic       i_exl,
    input  logic [4:0] i_exc_code,
    output logic       o_int_req,
    output logic       o_exc_req,
    output logic [4:0] o_code
);

    assign o_int_req = (|(i_hw_int & i_im)) & i_ie & ~i_exl;
    assign o_exc_req = (i_exc_code != 5'd0) & ~i_exl;
    assign o_code    = o_int_req ? c_exc_int : i_exc_code;

endmodule
`default_nettype wire

// File: rtl/cp0.sv
`default_nettype none
// ============================================================================
// Module      : cp0
// Description : Minimal MIPS coprocessor 0. It provides SR (12), Cause (13),
//               EPC (14) and, optionally, PRId (15). It raises req in the
//               same cycle that an exception or an enabled interrupt is seen
//               in M. At the next edge it records EPC, BD and ExcCode, and it
//               sets EXL.
// Ports       : clk, reset      - clock, synchronous active-high reset
//               en, cp0_addr,
//               cp0_wdata       - mtc0 write port (M stage)
//               cp0_rdata       - mfc0 combinational read data
//               vpc, bd_in      - PC and branch-delay flag of the M instr
//               exc_code_in     - pending exception code (0 = none)
//               hw_int          - level-sensitive interrupt lines
//               exl_clr         - eret in M
//               epc_out         - EPC register, for the eret redirect
//               req             - flush and redirect to the handler
// Config      : define CP0_PRID_EN to make reg 15 return PRID_VALUE.
// Revision    : 1.0 - initial release
// ============================================================================
module cp0
    import cp0_pkg::*;
#(
    parameter logic [31:0] PRID_VALUE = 32'h0000_4C01
)(
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic [4:0]  cp0_addr,
    input  logic [31:0] cp0_wdata,
    output logic [31:0] cp0_rdata,
    input  logic [31:0] vpc,
    input  logic        bd_in,
    input  logic [4:0]  exc_code_in,
    input  logic [5:0]  hw_int,
    input  logic        exl_clr,
    output logic [31:0] epc_out,
    output logic        req
);

    // Architectural state
    logic [5:0]  r_im;
    logic        r_exl;
    logic        r_ie;
    logic        r_bd;
    logic [5:0]  r_ip;
    logic [4:0]  r_exc_code;
    logic [31:0] r_epc;

    logic        w_int_req;
    logic        w_exc_req;
    logic [4:0]  w_code;
    logic [31:0] w_epc_next;

    cp0_exc_arb u_arb (
        .i_hw_int   (hw_int),
        .i_im       (r_im),
        .i_ie       (r_ie),
        .i_exl      (r_exl),
        .i_exc_code (exc_code_in),
        .o_int_req  (w_int_req),
        .o_exc_req  (w_exc_req),
        .o_code     (w_code)
    );

    // The reset gate keeps req low while reset is held. Otherwise a
    // pending exception code could raise req before EXL is defined.
    assign req = (w_int_req | w_exc_req) & ~reset;

    // If the faulting instruction is in a delay slot, EPC points back to
    // the branch so that the branch is re-executed on return.
    assign w_epc_next = bd_in ? (vpc - 32'd4) : vpc;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_im       <= 6'd0;
            r_exl      <= 1'b0;
            r_ie       <= 1'b0;
            r_bd       <= 1'b0;
            r_ip       <= 6'd0;
            r_exc_code <= 5'd0;
            r_epc      <= 32'd0;
        end else begin
            r_ip <= hw_int;
            if (req) begin
                // An exception entry overrides eret and any mtc0 in the same cycle
                r_exl      <= 1'b1;
                r_bd       <= bd_in;
                r_exc_code <= w_code;
                r_epc      <= w_epc_next;
            end else begin
                if (exl_clr) begin
                    r_exl <= 1'b0;
                end
                if (en) begin
                    case (cp0_addr)
                        c_reg_sr: begin
                            r_im  <= cp0_wdata[15:10];
                            r_exl <= cp0_wdata[1];
                            r_ie  <= cp0_wdata[0];
                        end
                        c_reg_epc: r_epc <= cp0_wdata;
                        default: ;
                    endcase
                end
            end
        end
    end

    always_comb begin
        cp0_rdata = 32'd0;
        case (cp0_addr)
            c_reg_sr:    cp0_rdata = {16'd0, r_im, 8'd0, r_exl, r_ie};
            c_reg_cause: cp0_rdata = {r_bd, 15'd0, r_ip, 3'd0, r_exc_code, 2'd0};
            c_reg_epc:   cp0_rdata = r_epc;
`ifdef CP0_PRID_EN
            c_reg_prid:  cp0_rdata = PRID_VALUE;
`endif
            default:     cp0_rdata = 32'd0;
        endcase
    end

`ifndef CP0_PRID_EN
    logic w_unused_prid;
    assign w_unused_prid = ^PRID_VALUE;
`endif

    assign epc_out = r_epc;

endmodule
`default_nettype wire

// File: doc/cp0.md
CP0 -- requirements
Module: cp0

Interface
REQ-001 SHALL expose parameter PRID_VALUE, default 32'h0000_4C01, the constant returned when PRId (reg 15) is read.
REQ-002 SHALL have port clk  input  1  the single rising-edge clock.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port en  input  1  mtc0 write enable, M stage.
REQ-005 SHALL have port cp0_addr  input  5  CP0 register number for read and write.
REQ-006 SHALL have port cp0_wdata  input  32  mtc0 write data.
REQ-007 SHALL have port cp0_rdata  output  32  mfc0 read data, combinational.
REQ-008 SHALL have port vpc  input  32  PC of the instruction currently in M.
REQ-009 SHALL have port bd_in  input  1  branch-delay flag of that instruction, produced in D and piped to M.
REQ-010 SHALL have port exc_code_in  input  5  pending exception code, 0 = none.
REQ-011 SHALL have port hw_int  input  6  external interrupt lines, level-sensitive.
REQ-012 SHALL have port exl_clr  input  1  eret in M.
REQ-013 SHALL have port epc_out  output  32  current EPC, for the eret redirect.
REQ-014 SHALL have port req  output  1  exception/interrupt taken, flush and redirect to 32'h0000_4180.

Function
REQ-015 SR (reg 12) SHALL implement only IM=SR[15:10], EXL=SR[1] and IE=SR[0]; all other bits SHALL read 0.
REQ-016 Cause (reg 13) SHALL hold BD=[31], IP=[15:10] and ExcCode=[6:2], SHALL read 0 elsewhere, and SHALL ignore mtc0.
REQ-017 Cause.IP SHALL load hw_int on every clock edge, independent of req.
REQ-018 EPC (reg 14) SHALL be fully writable by mtc0.
REQ-019 int_req SHALL be defined as |(hw_int & IM) & IE & !EXL, and exc_req as (exc_code_in!=0) & !EXL.
REQ-020 req SHALL equal int_req | exc_req, combinationally, in the same cycle.
REQ-021 When int_req and exc_req are both true, the interrupt SHALL win and the recorded ExcCode SHALL be 0.
REQ-022 On req, at the next edge: EXL<=1, BD<=bd_in, ExcCode<=winner, EPC<= bd_in ? vpc-4 : vpc, with 32-bit wrap.
REQ-023 An mtc0 issued in the same cycle as req SHALL be discarded.
REQ-024 exl_clr SHALL set EXL<=0 at the next edge; if req is also asserted, req SHALL take priority and EXL SHALL stay 1.
REQ-025 mtc0 to SR SHALL take effect at the next edge; an interrupt enabled by that write SHALL be raised no earlier than the following cycle.
REQ-026 epc_out SHALL output the EPC register, with no forwarding; an EPC write in cycle N SHALL be visible at N+1.
REQ-027 A read of any unimplemented address SHALL return 0; a write to one SHALL be ignored.

Reset
REQ-028 reset SHALL clear SR, Cause and EPC to 0 at the clock edge; req SHALL therefore be 0 while in reset.
REQ-029 reset SHALL override req, en and exl_clr sampled in the same cycle.

Configuration
REQ-030 With CP0_PRID_EN defined, a read of reg 15 SHALL return PRID_VALUE and writes to it SHALL be ignored.
REQ-031 Without CP0_PRID_EN, reg 15 SHALL behave as unimplemented and read 0.

Structure
REQ-032 Package cp0_pkg SHALL hold the register numbers (SR=12, CAUSE=13, EPC=14, PRID=15), the ExcCode constants (INT=0, ADEL=4, ADES=5, RI=10, OV=12) and the handler address 32'h0000_4180.
REQ-033 Combinational arbitration (int_req, exc_req, winner code) SHALL live in sub-module cp0_exc_arb; all state SHALL stay in cp0.

Verification
REQ-034 Scenario: mtc0 SR=32'h0000_FC03 -> read SR=32'h0000_FC03; mtc0 SR=32'hFFFF_FFFF -> read SR=32'h0000_FC03.
REQ-035 Scenario: SR=0x0401, hw_int=6'b000001, vpc=0x3010, bd_in=0 -> req=1 in the same cycle; next cycle EPC=0x3010, ExcCode=0, EXL=1, req=0.
REQ-036 Scenario: exc_code_in=12, vpc=0x3020, bd_in=1 -> EPC=0x301C, Cause[31]=1, Cause[6:2]=12.
REQ-037 Scenario: EXL=1, hw_int=6'b111111, exc_code_in=10 -> req=0; then exl_clr=1 -> EXL=0 next cycle and req=1 if IE and IM are set.
REQ-038 Scenario: req and en with cp0_addr=14 in the same cycle -> EPC equals the vpc-derived value, not cp0_wdata.
REQ-039 Scenario: reset asserted mid-handler with EXL=1 -> SR, Cause and EPC read 0 the next cycle; reg 15 reads PRID_VALUE with the macro defined and 0 without.
